// File: rtl/serial_word_reader_if.sv
// Parallel-load / serial-readout bus for serial_word_reader.
// The master drives load/din and the slave (the reader) drives the handshake and serial outputs.
interface serial_word_reader_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             done;

    modport master (
        output load, din,
        input  ready, sout, sout_valid, frame_start, done
    );

    modport slave (
        input  load, din,
        output ready, sout, sout_valid, frame_start, done
    );
endinterface

// File: rtl/serial_word_reader.sv
// Captures a WIDTH-bit word on a load/ready handshake and reads it out MSB first.
// Define SERIAL_WORD_READER_PARITY_EN to append an even-parity bit to every frame.
module serial_word_reader #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_word_reader_if.slave  bus
);
`ifdef SERIAL_WORD_READER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] capture_w;
    logic                 ready_q, sout_q, sout_valid_q, frame_start_q, done_q;

`ifdef SERIAL_WORD_READER_PARITY_EN
    assign capture_w = {bus.din, ^bus.din};
`else
    assign capture_w = bus.din;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.load && ready_q) begin
                    state_d = S_SHIFT;
                    shreg_d = capture_w;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            ready_q       <= 1'b0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            ready_q       <= (state_d == S_IDLE);
            sout_q        <= (state_d == S_SHIFT) && shreg_d[FRAME_LEN-1];
            sout_valid_q  <= (state_d == S_SHIFT);
            frame_start_q <= (state_d == S_SHIFT) && (state_q == S_IDLE);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign bus.ready       = ready_q;
    assign bus.sout        = sout_q;
    assign bus.sout_valid  = sout_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_serial_word_reader.sv
// Directed bench for serial_word_reader: WIDTH=8 frames, busy load, back-to-back, reset abort, WIDTH=1.
// Honours SERIAL_WORD_READER_PARITY_EN for the expected frame length.
module tb_serial_word_reader;
    localparam int WIDTH = 8;
`ifdef SERIAL_WORD_READER_PARITY_EN
    localparam int FLEN  = WIDTH + 1;
    localparam int FLEN1 = 2;
`else
    localparam int FLEN  = WIDTH;
    localparam int FLEN1 = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_word_reader_if #(.WIDTH(WIDTH)) bus ();
    serial_word_reader_if #(.WIDTH(1))     bus1 ();

    serial_word_reader #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    serial_word_reader #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load was accepted at the edge just before this call; checks the whole frame,
    // the done cycle and the ready cycle. busy_pulse presents load=1/din=FF at edge N+3.
    task automatic read_frame(input string tag, input logic [7:0] bits, input logic par,
                              input bit busy_pulse);
        logic exp_bit;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            exp_bit = (k < WIDTH) ? bits[WIDTH-1-k] : par;
            check($sformatf("%s sout[%0d]", tag, k), 32'(bus.sout), 32'(exp_bit));
            check($sformatf("%s valid[%0d]", tag, k), 32'(bus.sout_valid), 32'd1);
            check($sformatf("%s fstart[%0d]", tag, k), 32'(bus.frame_start), 32'(k == 0));
            check($sformatf("%s ready[%0d]", tag, k), 32'(bus.ready), 32'd0);
            check($sformatf("%s done[%0d]", tag, k), 32'(bus.done), 32'd0);
            if (busy_pulse && k == 2) begin
                bus.load = 1'b1;
                bus.din  = 8'hFF;
            end
            if (busy_pulse && k == 3) bus.load = 1'b0;
        end
        @(negedge clk);
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " done valid"}, 32'(bus.sout_valid), 32'd0);
        check({tag, " done sout"}, 32'(bus.sout), 32'd0);
        check({tag, " done ready"}, 32'(bus.ready), 32'd0);
        @(negedge clk);
        check({tag, " idle ready"}, 32'(bus.ready), 32'd1);
        check({tag, " idle done"}, 32'(bus.done), 32'd0);
        check({tag, " idle valid"}, 32'(bus.sout_valid), 32'd0);
    endtask

    // Present a word at the next edge and drop load just after it.
    task automatic start_frame(input logic [7:0] word);
        bus.load = 1'b1;
        bus.din  = word;
        @(posedge clk);
        #1 bus.load = 1'b0;
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.din   = '0;
        bus1.load = 1'b0;
        bus1.din  = '0;

        // Reset for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(bus.ready), 32'd0);
        check("rst valid", 32'(bus.sout_valid), 32'd0);
        check("rst sout", 32'(bus.sout), 32'd0);
        check("rst fstart", 32'(bus.frame_start), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst ready", 32'(bus.ready), 32'd1);

        // Basic frame; din changes while shifting must not matter.
        start_frame(8'hA5);
        bus.din = 8'h00;
        read_frame("a5", 8'hA5, 1'b0, 1'b0);

        // A load while busy is ignored; exactly one frame and one done.
        start_frame(8'h3C);
        read_frame("busy", 8'h3C, 1'b0, 1'b1);
        @(negedge clk);
        check("busy no 2nd frame", 32'(bus.sout_valid), 32'd0);
        check("busy no 2nd done", 32'(bus.done), 32'd0);

        // Back-to-back with load held high.
        bus.load = 1'b1;
        bus.din  = 8'h81;
        @(posedge clk);
        #1 bus.din = 8'h7E;
        read_frame("b2b1", 8'h81, 1'b0, 1'b0);
        read_frame("b2b2", 8'h7E, 1'b0, 1'b0);
        bus.load = 1'b0;
        @(negedge clk);

        // Reset during the 4th bit, with a competing load held through reset.
        start_frame(8'hF0);
        repeat (4) @(negedge clk);
        check("abort bit3 valid", 32'(bus.sout_valid), 32'd1);
        rst_n    = 1'b0;
        bus.load = 1'b1;
        bus.din  = 8'hFF;
        @(negedge clk);
        check("abort valid", 32'(bus.sout_valid), 32'd0);
        check("abort ready", 32'(bus.ready), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("abort rst-load valid", 32'(bus.sout_valid), 32'd0);
        check("abort rst-load done", 32'(bus.done), 32'd0);
        bus.load = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("abort rel ready", 32'(bus.ready), 32'd1);
        check("abort rel done", 32'(bus.done), 32'd0);
        start_frame(8'h0F);
        read_frame("0f", 8'h0F, 1'b0, 1'b0);

        // Odd-weight word so the parity bit is 1 in the parity build.
        start_frame(8'h07);
        read_frame("07", 8'h07, 1'b1, 1'b0);

        // WIDTH=1 instance.
        check("w1 ready", 32'(bus1.ready), 32'd1);
        bus1.load = 1'b1;
        bus1.din  = 1'b1;
        @(posedge clk);
        #1 bus1.load = 1'b0;
        for (int k = 0; k < FLEN1; k++) begin
            @(negedge clk);
            check($sformatf("w1 sout[%0d]", k), 32'(bus1.sout), 32'd1);
            check($sformatf("w1 valid[%0d]", k), 32'(bus1.sout_valid), 32'd1);
            check($sformatf("w1 fstart[%0d]", k), 32'(bus1.frame_start), 32'(k == 0));
            check($sformatf("w1 done[%0d]", k), 32'(bus1.done), 32'd0);
        end
        @(negedge clk);
        check("w1 done", 32'(bus1.done), 32'd1);
        check("w1 done valid", 32'(bus1.sout_valid), 32'd0);
        @(negedge clk);
        check("w1 ready back", 32'(bus1.ready), 32'd1);
        check("w1 done clear", 32'(bus1.done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
